// File: rtl/stopwatch_lap_cu.sv
// Stopwatch control unit: run/stop/clear sequencing plus lap snapshot capture,
// lap counting, timed auto-return from lap view, and the live/lap display mux.
module stopwatch_lap_cu #(
  parameter int LAP_HOLD_CYCLES = 300_000_000,
  parameter int HOLD_W          = 29,
  parameter int LAP_MAX         = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_lap,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  output logic       o_run,
  output logic       o_clear,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_lap_view,
  output logic [3:0] o_lap_cnt
);

  localparam int TIME_W = 24;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_capture;
  logic                w_hold_done;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [TIME_W-1:0]   r_snapshot;
  logic [3:0]          r_lap_cnt;
  logic [TIME_W-1:0]   w_live;
  logic [TIME_W-1:0]   w_disp;

  assign w_live      = {i_hour, i_min, i_sec, i_msec};
  assign w_hold_done = (r_hold_cnt == HOLD_W'(LAP_HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_STOP;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Clear only acts from STOP; in RUN/LAP it is ignored, so run then lap decide.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    o_run        = 1'b0;
    o_clear      = 1'b0;
    o_lap_view   = 1'b0;
    case (r_state)
      ST_STOP: begin
        if (i_btn_clear) begin
          w_state_next = ST_CLEAR;
        end else if (i_btn_run) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        o_run = 1'b1;
        if (i_btn_run) begin
          w_state_next = ST_STOP;
        end else if (i_btn_lap) begin
          w_state_next = ST_LAP;
          w_capture    = 1'b1;
        end
      end
      ST_LAP: begin
        o_run      = 1'b1;
        o_lap_view = 1'b1;
        if (i_btn_run) begin
          w_state_next = ST_STOP;
        end else if (i_btn_lap) begin
          w_capture = 1'b1;
        end else if (w_hold_done) begin
          w_state_next = ST_RUN;
        end
      end
      ST_CLEAR: begin
        o_clear      = 1'b1;
        w_state_next = ST_STOP;
      end
      default: begin
        w_state_next = ST_STOP;
      end
    endcase
  end

  // Snapshot and lap count are zeroed on the edge that enters CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snapshot <= '0;
      r_lap_cnt  <= '0;
    end else if (w_state_next == ST_CLEAR) begin
      r_snapshot <= '0;
      r_lap_cnt  <= '0;
    end else if (w_capture) begin
      r_snapshot <= w_live;
      if (r_lap_cnt < 4'(LAP_MAX)) begin
        r_lap_cnt <= r_lap_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else if (w_capture) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_LAP && w_state_next == ST_LAP) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end else begin
      r_hold_cnt <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TIME_W; gi = gi + 1) begin : g_disp_mux
      assign w_disp[gi] = (r_state == ST_LAP) ? r_snapshot[gi] : w_live[gi];
    end
  endgenerate

  assign {o_hour, o_min, o_sec, o_msec} = w_disp;
  assign o_lap_cnt = r_lap_cnt;

endmodule

// File: tb/tb_stopwatch_lap_cu.sv
// Bench for stopwatch_lap_cu: a vector table plus hand-built sequences for the
// hold timeout, hold restart, lap saturation and reset-in-LAP, checked via a scoreboard queue.
module tb_stopwatch_lap_cu;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_btn_run, i_btn_clear, i_btn_lap;
  logic [6:0] i_msec;
  logic [5:0] i_sec, i_min;
  logic [4:0] i_hour;
  logic       o_run, o_clear, o_lap_view;
  logic [6:0] o_msec;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic [3:0] o_lap_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit r, c, l;
    int ms, s, m, h;
    bit er, ec, ev;
    int ecnt;
    bit chk_cnt;
    int ems, es, em, eh;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[19];

  stopwatch_lap_cu #(
    .LAP_HOLD_CYCLES(10),
    .HOLD_W(4),
    .LAP_MAX(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_btn_run(i_btn_run),
    .i_btn_clear(i_btn_clear),
    .i_btn_lap(i_btn_lap),
    .i_msec(i_msec),
    .i_sec(i_sec),
    .i_min(i_min),
    .i_hour(i_hour),
    .o_run(o_run),
    .o_clear(o_clear),
    .o_msec(o_msec),
    .o_sec(o_sec),
    .o_min(o_min),
    .o_hour(o_hour),
    .o_lap_view(o_lap_view),
    .o_lap_cnt(o_lap_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(bit r, bit c, bit l, int ms, int s,
                              bit er, bit ec, bit ev, int ecnt, bit chk,
                              int ems, int es);
    vec_t v;
    v.r = r; v.c = c; v.l = l; v.ms = ms; v.s = s; v.m = 0; v.h = 0;
    v.er = er; v.ec = ec; v.ev = ev; v.ecnt = ecnt; v.chk_cnt = chk;
    v.ems = ems; v.es = es; v.em = 0; v.eh = 0;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    exp_q.push_back(v);
    i_btn_run   = v.r;
    i_btn_clear = v.c;
    i_btn_lap   = v.l;
    i_msec      = 7'(v.ms);
    i_sec       = 6'(v.s);
    i_min       = 6'(v.m);
    i_hour      = 5'(v.h);
    tick();
    e = exp_q.pop_front();
    check({tag, " run"},   int'(o_run),      int'(e.er));
    check({tag, " clear"}, int'(o_clear),    int'(e.ec));
    check({tag, " view"},  int'(o_lap_view), int'(e.ev));
    if (e.chk_cnt) check({tag, " lap_cnt"}, int'(o_lap_cnt), e.ecnt);
    check({tag, " msec"},  int'(o_msec), e.ems);
    check({tag, " sec"},   int'(o_sec),  e.es);
    check({tag, " min"},   int'(o_min),  e.em);
    check({tag, " hour"},  int'(o_hour), e.eh);
    $display("[TB] %s btn=%0d%0d%0d run=%0d clr=%0d view=%0d cnt=%0d disp=%0d:%0d:%0d.%0d",
             tag, v.r, v.c, v.l, o_run, o_clear, o_lap_view, o_lap_cnt,
             o_hour, o_min, o_sec, o_msec);
  endtask

  initial begin
    vec_t v;

    tbl[0]  = mk(0,0,0,  0,0, 0,0,0, 0,1,  0,0);
    tbl[1]  = mk(1,0,0,  0,0, 1,0,0, 0,1,  0,0);
    tbl[2]  = mk(0,0,0, 10,0, 1,0,0, 0,1, 10,0);
    tbl[3]  = mk(1,0,0, 10,0, 0,0,0, 0,1, 10,0);
    tbl[4]  = mk(0,1,0,  0,0, 0,1,0, 0,1,  0,0);
    tbl[5]  = mk(0,0,0,  0,0, 0,0,0, 0,1,  0,0);
    tbl[6]  = mk(1,0,0,  0,0, 1,0,0, 0,1,  0,0);
    tbl[7]  = mk(0,0,1, 42,5, 1,0,1, 1,1, 42,5);
    tbl[8]  = mk(0,0,0, 43,5, 1,0,1, 1,1, 42,5);
    tbl[9]  = mk(0,1,0, 50,6, 1,0,1, 1,1, 42,5);
    tbl[10] = mk(1,0,0, 60,6, 0,0,0, 1,1, 60,6);
    tbl[11] = mk(0,0,1, 61,6, 0,0,0, 1,1, 61,6);
    tbl[12] = mk(1,1,1, 62,6, 0,1,0, 0,0, 62,6);
    tbl[13] = mk(0,0,0, 63,6, 0,0,0, 0,1, 63,6);
    tbl[14] = mk(1,0,0,  0,0, 1,0,0, 0,1,  0,0);
    tbl[15] = mk(1,0,1, 70,0, 0,0,0, 0,1, 70,0);
    tbl[16] = mk(1,0,0,  0,0, 1,0,0, 0,1,  0,0);
    tbl[17] = mk(0,1,0,  1,0, 1,0,0, 0,1,  1,0);
    tbl[18] = mk(1,0,0,  2,0, 0,0,0, 0,1,  2,0);

    reset = 1'b1;
    i_btn_run = 0; i_btn_clear = 0; i_btn_lap = 0;
    i_msec = 0; i_sec = 0; i_min = 0; i_hour = 0;
    tick();
    tick();
    check("reset run",     int'(o_run),      0);
    check("reset clear",   int'(o_clear),    0);
    check("reset view",    int'(o_lap_view), 0);
    check("reset lap_cnt", int'(o_lap_cnt),  0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Hold timeout: view lasts exactly 10 cycles from entry
    apply(mk(1,0,0, 0,0, 1,0,0, 0,1, 0,0), "to_run");
    v = mk(0,0,1, 1,1, 1,0,1, 1,1, 1,1);
    v.h = 3; v.m = 7; v.eh = 3; v.em = 7;
    apply(v, "to_entry");
    for (int k = 1; k <= 9; k++) begin
      v = mk(0,0,0, 2,2, 1,0,1, 1,1, 1,1);
      v.h = 4; v.m = 8; v.eh = 3; v.em = 7;
      apply(v, $sformatf("to_hold%0d", k));
    end
    v = mk(0,0,0, 2,2, 1,0,0, 1,1, 2,2);
    v.h = 4; v.m = 8; v.eh = 4; v.em = 8;
    apply(v, "to_expire");

    // Lap at cycle 7 restarts the hold
    apply(mk(0,0,1, 3,0, 1,0,1, 2,1, 3,0), "rs_entry");
    for (int k = 1; k <= 6; k++)
      apply(mk(0,0,0, 9,9, 1,0,1, 2,1, 3,0), $sformatf("rs_hold%0d", k));
    apply(mk(0,0,1, 4,0, 1,0,1, 3,1, 4,0), "rs_relap");
    for (int k = 8; k <= 16; k++)
      apply(mk(0,0,0, 9,9, 1,0,1, 3,1, 4,0), $sformatf("rs_hold%0d", k));
    apply(mk(0,0,0, 9,9, 1,0,0, 3,1, 9,9), "rs_expire");

    // Saturation after a clear
    apply(mk(1,0,0, 0,0, 0,0,0, 3,1, 0,0), "sat_stop");
    apply(mk(0,1,0, 0,0, 0,1,0, 0,0, 0,0), "sat_clear");
    apply(mk(0,0,0, 0,0, 0,0,0, 0,1, 0,0), "sat_cleared");
    apply(mk(1,0,0, 0,0, 1,0,0, 0,1, 0,0), "sat_run");
    for (int i = 0; i < 17; i++)
      apply(mk(0,0,1, i,0, 1,0,1, (i + 1 > 15) ? 15 : i + 1, 1, i,0),
            $sformatf("sat_lap%0d", i));

    // Reset while in LAP with buttons held
    reset = 1'b1; i_btn_run = 1; i_btn_lap = 1; i_btn_clear = 0;
    i_msec = 7'd80; i_sec = 6'd1;
    tick();
    check("rstlap run",     int'(o_run),      0);
    check("rstlap clear",   int'(o_clear),    0);
    check("rstlap view",    int'(o_lap_view), 0);
    check("rstlap lap_cnt", int'(o_lap_cnt),  0);
    check("rstlap msec",    int'(o_msec),     80);
    $display("[TB] rstlap run=%0d view=%0d cnt=%0d msec=%0d", o_run, o_lap_view, o_lap_cnt, o_msec);
    reset = 1'b0; i_btn_run = 0; i_btn_lap = 0;
    tick();
    check("post_rst run",  int'(o_run),      0);
    check("post_rst view", int'(o_lap_view), 0);
    $display("[TB] post_rst run=%0d view=%0d", o_run, o_lap_view);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
